fp_normalizer: RTL and testbench

//  Consumer of the leading-zero count in the FP datapath. Takes an

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_norm_shift.sv | 39 +++
 rtl/fp_normalizer.sv | 102 ++++++++++
 tb/tb_fp_normalizer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants and the normalized beat format
// that travels from the normalizer to the rounder.
package fp_pkg;

  localparam int BIAS   = 7;
  localparam int MANT_W = 2 * BIAS + 1;
  localparam int CNT_W  = $clog2(MANT_W);
  localparam int EXP_W  = 4;

  // One normalized result: shifted mantissa, adjusted biased exponent, flags.
  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              uflow;
  } norm_beat_t;

endpackage

// File: rtl/fp_norm_shift.sv
// Combinational normalization: shifts the mantissa left by the leading-zero
// count, lowers the exponent to match, and clamps to subnormal when the
// exponent runs out before the leading one reaches the MSB.
module fp_norm_shift
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [CNT_W-1:0]  lz_i,
  output norm_beat_t        beat_o
);

  // A count of MANT_W (or more) means the LZD saw an all-zero mantissa.
  localparam logic [CNT_W-1:0] LZ_ALL_ZERO = CNT_W'(MANT_W);
  // Common width for the exponent-versus-count comparison.
  localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;

  logic [CMP_W-1:0] exp_cmp;
  logic [CMP_W-1:0] lz_cmp;

  assign exp_cmp = CMP_W'(exp_i);
  assign lz_cmp  = CMP_W'(lz_i);

  // Select zero / normal / underflow result; shifts discard bits above the MSB.
  always_comb begin
    beat_o = '0;
    if (lz_i >= LZ_ALL_ZERO) begin
      beat_o.zero = 1'b1;
    end else if (exp_cmp > lz_cmp) begin
      beat_o.mant = mant_i << lz_i;
      beat_o.exp  = exp_i - EXP_W'(lz_i);
    end else begin
      // Exponent exhausted: shift only as far as the exponent allows.
      beat_o.mant  = mant_i << CNT_W'(exp_i);
      beat_o.uflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Two-stage normalizer between the LZD and the rounder.
// S1 captures the raw {mantissa, exponent, count}; S2 holds the normalized
// result. Each stage carries only a full bit, so there is no other FSM.
//
// Handshake: a beat moves on an interface in any cycle where its valid and
// ready are both high at the rising edge. The output beat (vld_o, data,
// flags) is held unchanged while vld_o=1 and rdy_i=0. rdy_o does not depend
// on vld_i, and vld_i may be withdrawn without a transfer.
module fp_normalizer
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic [MANT_W-1:0] mant_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [CNT_W-1:0]  lz_i,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              zero_o,
  output logic              uflow_o
);

  logic              s1_full_q, s1_full_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [EXP_W-1:0]  s1_exp_q,  s1_exp_d;
  logic [CNT_W-1:0]  s1_lz_q,   s1_lz_d;
  logic              s2_full_q, s2_full_d;
  norm_beat_t        s2_beat_q, s2_beat_d;
  norm_beat_t        calc_beat;

  logic adv1;
  logic adv2;
  logic acc;

  // S2 frees when empty or delivering; S1 moves forward whenever S2 frees.
  assign adv2  = ~s2_full_q | rdy_i;
  assign adv1  = adv2;
  assign rdy_o = ~rst & (~s1_full_q | adv1);
  assign acc   = vld_i & rdy_o;

  fp_norm_shift u_shift (
    .mant_i (s1_mant_q),
    .exp_i  (s1_exp_q),
    .lz_i   (s1_lz_q),
    .beat_o (calc_beat)
  );

  // Next-state for both stages: load on accept, advance when downstream frees.
  always_comb begin
    s1_full_d = s1_full_q;
    s1_mant_d = s1_mant_q;
    s1_exp_d  = s1_exp_q;
    s1_lz_d   = s1_lz_q;
    s2_full_d = s2_full_q;
    s2_beat_d = s2_beat_q;
    if (rdy_o) begin
      s1_full_d = vld_i;
    end
    if (acc) begin
      s1_mant_d = mant_i;
      s1_exp_d  = exp_i;
      s1_lz_d   = lz_i;
    end
    if (adv2) begin
      s2_full_d = s1_full_q;
      if (s1_full_q) begin
        s2_beat_d = calc_beat;
      end
    end
  end

  // Stage registers; reset empties both stages and drops in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_q <= 1'b0;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_lz_q   <= '0;
      s2_full_q <= 1'b0;
      s2_beat_q <= '0;
    end else begin
      s1_full_q <= s1_full_d;
      s1_mant_q <= s1_mant_d;
      s1_exp_q  <= s1_exp_d;
      s1_lz_q   <= s1_lz_d;
      s2_full_q <= s2_full_d;
      s2_beat_q <= s2_beat_d;
    end
  end

  // Outputs read zero for as long as reset is asserted.
  assign vld_o   = s2_full_q & ~rst;
  assign mant_o  = rst ? '0 : s2_beat_q.mant;
  assign exp_o   = rst ? '0 : s2_beat_q.exp;
  assign zero_o  = s2_beat_q.zero & ~rst;
  assign uflow_o = s2_beat_q.uflow & ~rst;

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: directed cases, bursts with and without
// back-pressure, reset with beats in flight, and a randomized phase, all
// scored against an arithmetic reference model through an expected queue.
module tb_fp_normalizer;

  localparam int MW = 15;
  localparam int EW = 4;
  localparam int CW = 4;
  localparam int BW = MW + EW + 2;

  logic          clk;
  logic          rst;
  logic          vld_i;
  logic          rdy_o;
  logic [MW-1:0] mant_i;
  logic [EW-1:0] exp_i;
  logic [CW-1:0] lz_i;
  logic          vld_o;
  logic          rdy_i;
  logic [MW-1:0] mant_o;
  logic [EW-1:0] exp_o;
  logic          zero_o;
  logic          uflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_deliv  = 0;
  int idle_run = 0;
  int deliv_cyc[$];
  logic [BW-1:0] exp_q[$];

  logic          stall_prev = 1'b0;
  logic [BW-1:0] held_beat  = '0;

  fp_normalizer dut (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .mant_i  (mant_i),
    .exp_i   (exp_i),
    .lz_i    (lz_i),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .mant_o  (mant_o),
    .exp_o   (exp_o),
    .zero_o  (zero_o),
    .uflow_o (uflow_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Normalization from the arithmetic rules: multiply by 2^shift, keep MW bits.
  function automatic logic [BW-1:0] ref_norm(input int m, input int e, input int lz);
    int r;
    logic [MW-1:0] rm;
    logic [EW-1:0] re;
    if (lz >= MW) return {{MW{1'b0}}, {EW{1'b0}}, 1'b1, 1'b0};
    if (e > lz) begin
      r  = (m * (1 << lz)) % (1 << MW);
      rm = r[MW-1:0];
      re = EW'(e - lz);
      return {rm, re, 1'b0, 1'b0};
    end
    r  = (m * (1 << e)) % (1 << MW);
    rm = r[MW-1:0];
    return {rm, {EW{1'b0}}, 1'b0, 1'b1};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  // Sampled on the falling edge: predicts the transfers of the coming rising edge.
  always @(negedge clk) begin
    logic [BW-1:0] got;
    logic [BW-1:0] want;
    got = {mant_o, exp_o, zero_o, uflow_o};
    if (rst) begin
      check("rst_vld_o", 32'(vld_o), 0);
      check("rst_rdy_o", 32'(rdy_o), 0);
      check("rst_data", 32'(got), 0);
      exp_q.delete();
      stall_prev = 1'b0;
      idle_run   = 0;
    end else begin
      check("occupancy", 32'(exp_q.size() <= 2), 1);
      check("rdy_o", 32'(rdy_o), 32'(!(exp_q.size() == 2 && !rdy_i)));
      if (stall_prev) begin
        check("hold_vld", 32'(vld_o), 1);
        check("hold_data", 32'(got), 32'(held_beat));
      end
      if (vld_o && exp_q.size() == 0) check("spurious_vld", 32'(vld_o), 0);
      if (vld_o && rdy_i && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("data", 32'(got), 32'(want));
        n_deliv++;
        deliv_cyc.push_back(cyc);
        idle_run = 0;
      end else if (exp_q.size() > 0 && rdy_i) begin
        idle_run++;
        if (idle_run > 3) begin
          check("latency_bound", 32'(idle_run), 3);
          idle_run = 0;
        end
      end
      if (vld_i && rdy_o) exp_q.push_back(ref_norm(int'(mant_i), int'(exp_i), int'(lz_i)));
      stall_prev = vld_o && !rdy_i;
      held_beat  = got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    vld_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic [CW-1:0] lz);
    logic acc;
    int   tries;
    vld_i  = 1'b1;
    mant_i = m;
    exp_i  = e;
    lz_i   = lz;
    acc    = 1'b0;
    tries  = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = rdy_o;
      @(posedge clk); #1;
      tries++;
    end
    if (!acc) check("accept_timeout", 32'(tries), 0);
    vld_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic send_random_beat();
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic [CW-1:0] lz;
    m  = MW'($urandom_range(0, (1 << MW) - 1));
    e  = EW'($urandom_range(0, 15));
    lz = CW'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) lz = CW'(15);
    send_beat(m, e, lz);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    rst    = 1'b1;
    vld_i  = 1'b0;
    rdy_i  = 1'b1;
    mant_i = '0;
    exp_i  = '0;
    lz_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy_o", 32'(rdy_o), 1);
    check("post_rst_vld_o", 32'(vld_o), 0);
    @(posedge clk); #1;

    // Directed: latency and the three arithmetic cases.
    vld_i = 1'b1; mant_i = 15'h0800; exp_i = 4'd9; lz_i = 4'd3;
    @(posedge clk); #1;
    vld_i = 1'b0;
    @(negedge clk);
    check("lat_cycle1_vld", 32'(vld_o), 0);
    @(negedge clk);
    check("lat_cycle2_vld", 32'(vld_o), 1);
    check("normal_mant", 32'(mant_o), 32'h4000);
    check("normal_exp", 32'(exp_o), 6);
    check("normal_flags", 32'({zero_o, uflow_o}), 0);
    @(posedge clk); #1;
    send_beat(15'h0000, 4'd5, 4'd15);
    @(negedge clk); @(negedge clk);
    check("zero_vld", 32'(vld_o), 1);
    check("zero_result", 32'({mant_o, exp_o, zero_o, uflow_o}), 32'({15'h0, 4'h0, 1'b1, 1'b0}));
    @(posedge clk); #1;
    send_beat(15'h0040, 4'd3, 4'd8);
    @(negedge clk); @(negedge clk);
    check("uflow_vld", 32'(vld_o), 1);
    check("uflow_result", 32'({mant_o, exp_o, zero_o, uflow_o}), 32'({15'h0200, 4'h0, 1'b0, 1'b1}));
    @(posedge clk); #1;
    send_beat(15'h1234, 4'd0, 4'd2);
    send_beat(15'h7fff, 4'd4, 4'd4);
    send_beat(15'h0001, 4'd15, 4'd14);
    drain("drain_directed");

    // Full-rate burst: eight results on eight consecutive cycles.
    deliv_cyc.delete();
    for (int i = 0; i < 8; i++) send_beat(MW'(15'h0100 >> i), EW'(10 + (i % 4)), CW'(6 + i));
    drain("drain_burst");
    check("burst_count", 32'(deliv_cyc.size()), 8);
    if (deliv_cyc.size() == 8) check("burst_back_to_back", 32'(deliv_cyc[7] - deliv_cyc[0]), 7);

    // Same burst with rdy_i low on burst cycles 3..5.
    start = n_deliv;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(MW'(15'h0100 >> i), EW'(10 + (i % 4)), CW'(6 + i));
      end
      begin
        for (int c = 0; c < 8; c++) begin
          rdy_i = !(c >= 3 && c <= 5);
          @(posedge clk); #1;
        end
        rdy_i = 1'b1;
      end
    join
    drain("drain_stall");
    check("stall_count", 32'(n_deliv - start), 8);

    // Reset with two beats in flight: nothing stale may appear afterwards.
    vld_i = 1'b1; mant_i = 15'h0123; exp_i = 4'd8; lz_i = 4'd1;
    @(posedge clk); #1;
    mant_i = 15'h0456; lz_i = 4'd2;
    @(posedge clk); #1;
    vld_i = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("rst_inflight_vld", 32'(vld_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_rdy", 32'(rdy_o), 1);
    check("rst_release_vld", 32'(vld_o), 0);
    idle(5);
    check("rst_no_stale", 32'(exp_q.size()), 0);

    // Randomized phase with random back-pressure and input gaps.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send_random_beat();
        end
      end
      begin
        for (int c = 0; c < 1200; c++) begin
          rdy_i = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        rdy_i = 1'b1;
      end
    join
    rdy_i = 1'b1;
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
